alu_writeback: RTL and testbench
================================

// Module: alu_writeback
// PURPOSE
//  Execute/writeback stage downstream of the ALU. Owns the architectural accumulator and Z/C flags,
//  which feed back to the ALU's accum/cin inputs, and registers register-file writes one cycle
//  after execute. Applies skip (squash next instruction), and handles interrupt
//  context save/restore (accum, Z, C, skip state).
// PARAMETERS
//  REG_ADDR_W   5      register-file address width
//  ACCUM_RESET  8'h00  accumulator value after reset
// PORTS
//  clk          in   1           clock; all state on rising edge
//  reset_n      in   1           asynchronous, active-low reset
//  in_valid     in   1           ALU outputs below describe a real instruction this cycle
//  stall        in   1           hold stage; instruction not accepted
//  alu_result   in   8           ALU result
//  accum_write  in   1           write result to accumulator
//  reg_write    in   1           write result to register file
//  reg_addr     in   REG_ADDR_W  destination register
//  z_write      in   1           update Z from zout
//  zout         in   1           result==0
//  c_write      in   1           update C from cout
//  cout         in   1           carry out
//  retint       in   1           return-from-interrupt instruction
//  skip         in   1           squash next accepted instruction
//  int_enter    in   1           1-cycle pulse: interrupt taken, save context
//  accum        out  8           architectural accumulator (to ALU)
//  z_flag       out  1           Z flag
//  c_flag       out  1           C flag (to ALU cin)
//  skip_pending out  1           next accepted instruction will be squashed
//  rf_we        out  1           register-file write enable (registered)
//  rf_waddr     out  REG_ADDR_W  register-file write address
//  rf_wdata     out  8           register-file write data; also bypass source
//  intr_return  out  1           1-cycle pulse, cycle after an executed retint
// BEHAVIOUR
//  - Reset (async, reset_n=0): accum=ACCUM_RESET, z=c=0, state=NORMAL, skip_pending=0, rf_we=0,
//    rf_waddr=0, rf_wdata=0, intr_return=0, shadow {accum,z,c,skip}=0.
//  - accept = in_valid & ~stall. Nothing changes on non-accept cycles except int_enter handling.
//  - FSM: NORMAL, SKIP_PEND. skip_pending = (state==SKIP_PEND).
//    NORMAL + accept & skip -> SKIP_PEND. SKIP_PEND + accept -> NORMAL; that instruction is
//    squashed (no accum/flag/rf write, retint ignored, its skip ignored; skips never chain).
//  - Executed (accepted, not squashed) instruction, same edge (0 latency): accum<=alu_result if
//    accum_write; z<=zout if z_write; c<=cout if c_write.
//  - rf write, 1-cycle latency: on edge of an executed reg_write: rf_we<=1, rf_waddr<=reg_addr,
//    rf_wdata<=alu_result. Otherwise rf_we<=0 (bubble); addr/data hold.
//  - Upstream bypasses rf_wdata when rf_we && rf_waddr==source reg (this block has no read port).
//  - Executed retint: accum/z/c/state restored from shadow; its own accum/z/c writes discarded;
//    intr_return<=1 for exactly one cycle. reg_write of retint still honoured.
//  - int_enter: shadow<={accum,z,c,skip} using post-edge values (incl. same-cycle executed
//    instruction); state<=NORMAL so the first ISR instruction is never squashed. Sampled
//    regardless of stall.
//  - int_enter with executed retint same cycle: restore first, then shadow<=restored
//    context, state<=NORMAL (back-to-back interrupt).
//  - Single-level shadow; nested int_enter overwrites shadow.
// TESTING
//  1 Reset: assert reset_n=0 mid-stream with rf_we=1 -> all outputs immediately reset values, accum=ACCUM_RESET.
//  2 Accept result=8'h00, accum_write,z_write,c_write, cout=1 -> same edge accum=00,z=1,c=1; rf_we stays 0.
//  3 Accept reg_write addr=5 data=8'h3C -> next cycle rf_we=1,waddr=5,wdata=3C; following idle cycle rf_we=0.
//  4 Skip then two instrs writing accum=11,22 with stall=1 between -> 11 squashed, accum=22, skip_pending 1->0.
//  5 accum=AA,z=0,c=1,SKIP_PEND; int_enter -> skip_pending=0; ISR writes accum=55,z=1; retint -> AA,0,1,SKIP_PEND; intr_return 1 cycle.
//  6 Executed retint + int_enter same cycle -> context restored; shadow=restored values; skip_pending=0.

Source files
------------

// File: rtl/alu_writeback.sv
// Execute/writeback stage: owns the accumulator and Z/C flags, registers
// register-file writes one cycle after execute, squashes the instruction
// after a skip, and saves/restores context around interrupts.
module alu_writeback #(
    parameter int unsigned     REG_ADDR_W  = 5,
    parameter logic      [7:0] ACCUM_RESET = 8'h00
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  in_valid,
    input  logic                  stall,
    input  logic [7:0]            alu_result,
    input  logic                  accum_write,
    input  logic                  reg_write,
    input  logic [REG_ADDR_W-1:0] reg_addr,
    input  logic                  z_write,
    input  logic                  zout,
    input  logic                  c_write,
    input  logic                  cout,
    input  logic                  retint,
    input  logic                  skip,
    input  logic                  int_enter,
    output logic [7:0]            accum,
    output logic                  z_flag,
    output logic                  c_flag,
    output logic                  skip_pending,
    output logic                  rf_we,
    output logic [REG_ADDR_W-1:0] rf_waddr,
    output logic [7:0]            rf_wdata,
    output logic                  intr_return
);

    localparam logic [0:0] StNormal   = 1'b0;
    localparam logic [0:0] StSkipPend = 1'b1;

    logic [0:0]            state_q, state_d;
    logic [7:0]            accum_q, accum_d;
    logic                  z_q, z_d;
    logic                  c_q, c_d;
    logic [7:0]            sh_accum_q, sh_accum_d;
    logic                  sh_z_q, sh_z_d;
    logic                  sh_c_q, sh_c_d;
    logic                  sh_skip_q, sh_skip_d;
    logic                  rf_we_q, rf_we_d;
    logic [REG_ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
    logic [7:0]            rf_wdata_q, rf_wdata_d;
    logic                  intr_return_q, intr_return_d;

    logic accept;
    logic squash;
    logic exec;
    logic exec_ret;

    assign accept   = in_valid & ~stall;
    assign squash   = accept & (state_q == StSkipPend);
    assign exec     = accept & (state_q == StNormal);
    assign exec_ret = exec & retint;

    // Architectural context, skip FSM and interrupt shadow next-state
    always_comb begin
        state_d    = state_q;
        accum_d    = accum_q;
        z_d        = z_q;
        c_d        = c_q;
        sh_accum_d = sh_accum_q;
        sh_z_d     = sh_z_q;
        sh_c_d     = sh_c_q;
        sh_skip_d  = sh_skip_q;

        if (exec_ret) begin
            // Restore wins over the retint's own accum/flag writes and its skip
            accum_d = sh_accum_q;
            z_d     = sh_z_q;
            c_d     = sh_c_q;
            state_d = sh_skip_q ? StSkipPend : StNormal;
        end else if (exec) begin
            if (accum_write) accum_d = alu_result;
            if (z_write)     z_d     = zout;
            if (c_write)     c_d     = cout;
            if (skip)        state_d = StSkipPend;
        end else if (squash) begin
            // Squashed instruction's own skip is ignored: skips never chain
            state_d = StNormal;
        end

        // Save the post-edge context, then force NORMAL so the ISR's first
        // instruction always executes
        if (int_enter) begin
            sh_accum_d = accum_d;
            sh_z_d     = z_d;
            sh_c_d     = c_d;
            sh_skip_d  = (state_d == StSkipPend);
            state_d    = StNormal;
        end
    end

    // Register-file write port and return pulse next-state
    always_comb begin
        rf_we_d       = exec & reg_write;
        rf_waddr_d    = rf_waddr_q;
        rf_wdata_d    = rf_wdata_q;
        intr_return_d = exec_ret;
        if (rf_we_d) begin
            rf_waddr_d = reg_addr;
            rf_wdata_d = alu_result;
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= StNormal;
            accum_q       <= ACCUM_RESET;
            z_q           <= 1'b0;
            c_q           <= 1'b0;
            sh_accum_q    <= 8'h00;
            sh_z_q        <= 1'b0;
            sh_c_q        <= 1'b0;
            sh_skip_q     <= 1'b0;
            rf_we_q       <= 1'b0;
            rf_waddr_q    <= '0;
            rf_wdata_q    <= 8'h00;
            intr_return_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            accum_q       <= accum_d;
            z_q           <= z_d;
            c_q           <= c_d;
            sh_accum_q    <= sh_accum_d;
            sh_z_q        <= sh_z_d;
            sh_c_q        <= sh_c_d;
            sh_skip_q     <= sh_skip_d;
            rf_we_q       <= rf_we_d;
            rf_waddr_q    <= rf_waddr_d;
            rf_wdata_q    <= rf_wdata_d;
            intr_return_q <= intr_return_d;
        end
    end

    assign accum        = accum_q;
    assign z_flag       = z_q;
    assign c_flag       = c_q;
    assign skip_pending = (state_q == StSkipPend);
    assign rf_we        = rf_we_q;
    assign rf_waddr     = rf_waddr_q;
    assign rf_wdata     = rf_wdata_q;
    assign intr_return  = intr_return_q;

endmodule

// File: tb/tb_alu_writeback.sv
// Testbench for alu_writeback: directed scenarios plus a randomized run
// checked against a behavioural model of the stage.
module tb_alu_writeback;

    localparam int unsigned AW = 5;
    localparam logic [7:0]  ACC_RST = 8'h00;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          in_valid, stall, accum_write, reg_write, z_write, zout;
    logic          c_write, cout, retint, skip, int_enter;
    logic [7:0]    alu_result;
    logic [AW-1:0] reg_addr;
    logic [7:0]    accum;
    logic          z_flag, c_flag, skip_pending, rf_we, intr_return;
    logic [AW-1:0] rf_waddr;
    logic [7:0]    rf_wdata;

    int n_checks = 0;
    int n_fail = 0;

    // Behavioural model state
    logic [7:0]    m_accum, m_rf_wdata, sh_accum;
    logic          m_z, m_c, m_skip, m_rf_we, m_intr, sh_z, sh_c, sh_skip;
    logic [AW-1:0] m_rf_waddr;

    always #5 clk = ~clk;

    alu_writeback #(.REG_ADDR_W(AW), .ACCUM_RESET(ACC_RST)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .stall(stall),
        .alu_result(alu_result), .accum_write(accum_write), .reg_write(reg_write),
        .reg_addr(reg_addr), .z_write(z_write), .zout(zout), .c_write(c_write),
        .cout(cout), .retint(retint), .skip(skip), .int_enter(int_enter),
        .accum(accum), .z_flag(z_flag), .c_flag(c_flag), .skip_pending(skip_pending),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .intr_return(intr_return)
    );

    task automatic idle();
        in_valid = 0; stall = 0; alu_result = 0; accum_write = 0; reg_write = 0;
        reg_addr = 0; z_write = 0; zout = 0; c_write = 0; cout = 0; retint = 0;
        skip = 0; int_enter = 0;
    endtask

    // Present one valid instruction; flags z/c are written when zw/cw set
    task automatic issue(input logic [7:0] res, input logic aw, input logic zw,
                         input logic zo, input logic cw, input logic co,
                         input logic ret, input logic sk);
        idle();
        in_valid = 1; alu_result = res; accum_write = aw; z_write = zw; zout = zo;
        c_write = cw; cout = co; retint = ret; skip = sk;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle();
        reset_n = 0;
        #3 reset_n = 1;
        issue(8'h5A, 1, 1, 0, 1, 1, 0, 1);
        reg_write = 1; reg_addr = 7;
        tick();
        n_checks++;
        if ({rf_we, rf_waddr, rf_wdata, accum, skip_pending} !== {1'b1, 5'd7, 8'h5A, 8'h5A, 1'b1}) begin
            n_fail++;
            $display("FAIL pre_reset: got we=%b a=%0d d=%h acc=%h sp=%b", rf_we, rf_waddr,
                     rf_wdata, accum, skip_pending);
        end
        idle();
        #2 reset_n = 0;
        #1;
        n_checks++;
        if ({accum, z_flag, c_flag, skip_pending, rf_we, rf_waddr, rf_wdata, intr_return}
            !== {ACC_RST, 4'b0, 5'd0, 8'h00, 1'b0}) begin
            n_fail++;
            $display("FAIL async_reset: got acc=%h z=%b c=%b sp=%b we=%b a=%0d d=%h ir=%b want all reset",
                     accum, z_flag, c_flag, skip_pending, rf_we, rf_waddr, rf_wdata, intr_return);
        end
        #1 reset_n = 1;
        tick();
    endtask

    task automatic test_flags();
        issue(8'h7F, 1, 1, 0, 1, 0, 0, 0);
        tick();
        issue(8'h00, 1, 1, 1, 1, 1, 0, 0);
        tick();
        n_checks++;
        if ({accum, z_flag, c_flag, rf_we} !== {8'h00, 1'b1, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL flags_zero: got acc=%h z=%b c=%b we=%b want 00 1 1 0",
                     accum, z_flag, c_flag, rf_we);
        end
        // Stalled instruction must not change anything
        issue(8'h42, 1, 1, 0, 1, 0, 0, 0);
        stall = 1;
        tick();
        n_checks++;
        if ({accum, z_flag, c_flag} !== {8'h00, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL stall_hold: got acc=%h z=%b c=%b want 00 1 1", accum, z_flag, c_flag);
        end
    endtask

    task automatic test_rf_write();
        issue(8'h3C, 0, 0, 0, 0, 0, 0, 0);
        reg_write = 1; reg_addr = 5;
        tick();
        n_checks++;
        if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd5, 8'h3C}) begin
            n_fail++;
            $display("FAIL rf_write: got we=%b a=%0d d=%h want 1 5 3c", rf_we, rf_waddr, rf_wdata);
        end
        idle();
        tick();
        n_checks++;
        if ({rf_we, rf_waddr, rf_wdata} !== {1'b0, 5'd5, 8'h3C}) begin
            n_fail++;
            $display("FAIL rf_bubble: got we=%b a=%0d d=%h want 0 5 3c", rf_we, rf_waddr, rf_wdata);
        end
        issue(8'hEE, 0, 0, 0, 0, 0, 0, 0);
        reg_write = 1; reg_addr = 9; stall = 1;
        tick();
        n_checks++;
        if ({rf_we, rf_waddr, rf_wdata} !== {1'b0, 5'd5, 8'h3C}) begin
            n_fail++;
            $display("FAIL rf_stall: got we=%b a=%0d d=%h want 0 5 3c", rf_we, rf_waddr, rf_wdata);
        end
    endtask

    task automatic test_skip();
        issue(8'h00, 0, 0, 0, 0, 0, 0, 1);
        tick();
        n_checks++;
        if (skip_pending !== 1'b1) begin
            n_fail++;
            $display("FAIL skip_set: got sp=%b want 1", skip_pending);
        end
        issue(8'h11, 1, 0, 0, 0, 0, 0, 1);
        stall = 1;
        tick();
        stall = 0;
        n_checks++;
        if ({skip_pending, accum} !== {1'b1, 8'h00}) begin
            n_fail++;
            $display("FAIL skip_stall: got sp=%b acc=%h want 1 00", skip_pending, accum);
        end
        reg_write = 1; reg_addr = 3;
        tick();
        n_checks++;
        if ({skip_pending, accum, rf_we} !== {1'b0, 8'h00, 1'b0}) begin
            n_fail++;
            $display("FAIL skip_squash: got sp=%b acc=%h we=%b want 0 00 0", skip_pending, accum, rf_we);
        end
        issue(8'h22, 1, 0, 0, 0, 0, 0, 0);
        tick();
        n_checks++;
        if ({skip_pending, accum} !== {1'b0, 8'h22}) begin
            n_fail++;
            $display("FAIL skip_next: got sp=%b acc=%h want 0 22", skip_pending, accum);
        end
    endtask

    task automatic test_interrupt();
        issue(8'hAA, 1, 1, 0, 1, 1, 0, 1);
        tick();
        idle();
        int_enter = 1;
        tick();
        n_checks++;
        if ({skip_pending, accum, z_flag, c_flag} !== {1'b0, 8'hAA, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL int_enter: got sp=%b acc=%h z=%b c=%b want 0 aa 0 1",
                     skip_pending, accum, z_flag, c_flag);
        end
        issue(8'h55, 1, 1, 1, 0, 0, 0, 0);
        tick();
        n_checks++;
        if ({accum, z_flag, c_flag} !== {8'h55, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL isr_exec: got acc=%h z=%b c=%b want 55 1 1", accum, z_flag, c_flag);
        end
        issue(8'h77, 1, 1, 1, 1, 0, 1, 0);
        tick();
        n_checks++;
        if ({accum, z_flag, c_flag, skip_pending, intr_return}
            !== {8'hAA, 1'b0, 1'b1, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL retint: got acc=%h z=%b c=%b sp=%b ir=%b want aa 0 1 1 1",
                     accum, z_flag, c_flag, skip_pending, intr_return);
        end
        idle();
        tick();
        n_checks++;
        if ({intr_return, skip_pending} !== 2'b01) begin
            n_fail++;
            $display("FAIL ir_pulse: got ir=%b sp=%b want 0 1", intr_return, skip_pending);
        end
        issue(8'h33, 1, 0, 0, 0, 0, 0, 0);
        tick();
        n_checks++;
        if ({accum, skip_pending} !== {8'hAA, 1'b0}) begin
            n_fail++;
            $display("FAIL restored_skip: got acc=%h sp=%b want aa 0", accum, skip_pending);
        end
    endtask

    task automatic test_back_to_back();
        // Interrupt taken alongside an executed skip: shadow = {10,0,0,skip}
        issue(8'h10, 1, 1, 0, 1, 0, 0, 1);
        int_enter = 1;
        tick();
        n_checks++;
        if ({accum, skip_pending} !== {8'h10, 1'b0}) begin
            n_fail++;
            $display("FAIL enter_exec: got acc=%h sp=%b want 10 0", accum, skip_pending);
        end
        issue(8'h20, 1, 1, 1, 1, 1, 0, 0);
        tick();
        issue(8'h99, 1, 1, 1, 1, 1, 1, 0);
        int_enter = 1;
        tick();
        n_checks++;
        if ({accum, z_flag, c_flag, skip_pending, intr_return}
            !== {8'h10, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL ret_and_enter: got acc=%h z=%b c=%b sp=%b ir=%b want 10 0 0 0 1",
                     accum, z_flag, c_flag, skip_pending, intr_return);
        end
        issue(8'h30, 1, 1, 1, 0, 0, 0, 0);
        tick();
        issue(8'h00, 0, 0, 0, 0, 0, 1, 0);
        tick();
        n_checks++;
        if ({accum, z_flag, c_flag, skip_pending} !== {8'h10, 1'b0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL shadow_resaved: got acc=%h z=%b c=%b sp=%b want 10 0 0 1",
                     accum, z_flag, c_flag, skip_pending);
        end
        idle();
        tick();
    endtask

    // Advance the model by one clock edge using the currently driven inputs
    task automatic model_step();
        logic acc_ok;
        acc_ok  = in_valid && !stall;
        m_rf_we = 0;
        m_intr  = 0;
        if (acc_ok && m_skip) begin
            m_skip = 0;
        end else if (acc_ok) begin
            if (reg_write) begin
                m_rf_we = 1; m_rf_waddr = reg_addr; m_rf_wdata = alu_result;
            end
            if (retint) begin
                m_accum = sh_accum; m_z = sh_z; m_c = sh_c; m_skip = sh_skip; m_intr = 1;
            end else begin
                if (accum_write) m_accum = alu_result;
                if (z_write) m_z = zout;
                if (c_write) m_c = cout;
                if (skip) m_skip = 1;
            end
        end
        if (int_enter) begin
            sh_accum = m_accum; sh_z = m_z; sh_c = m_c; sh_skip = m_skip;
            m_skip = 0;
        end
    endtask

    task automatic test_random();
        idle();
        reset_n = 0;
        #2 reset_n = 1;
        m_accum = ACC_RST; m_z = 0; m_c = 0; m_skip = 0; m_rf_we = 0; m_intr = 0;
        m_rf_waddr = 0; m_rf_wdata = 0; sh_accum = 0; sh_z = 0; sh_c = 0; sh_skip = 0;
        for (int i = 0; i < 600; i++) begin
            in_valid    = ($urandom_range(0, 3) != 0);
            stall       = ($urandom_range(0, 4) == 0);
            alu_result  = 8'($urandom);
            accum_write = $urandom_range(0, 1) == 1;
            reg_write   = $urandom_range(0, 1) == 1;
            reg_addr    = AW'($urandom);
            z_write     = $urandom_range(0, 1) == 1;
            zout        = $urandom_range(0, 1) == 1;
            c_write     = $urandom_range(0, 1) == 1;
            cout        = $urandom_range(0, 1) == 1;
            retint      = ($urandom_range(0, 6) == 0);
            skip        = ($urandom_range(0, 3) == 0);
            int_enter   = ($urandom_range(0, 8) == 0);
            model_step();
            tick();
            n_checks++;
            if ({accum, z_flag, c_flag, skip_pending, rf_we, rf_waddr, rf_wdata, intr_return}
                !== {m_accum, m_z, m_c, m_skip, m_rf_we, m_rf_waddr, m_rf_wdata, m_intr}) begin
                n_fail++;
                $display("FAIL random[%0d]: got acc=%h z=%b c=%b sp=%b we=%b a=%0d d=%h ir=%b want acc=%h z=%b c=%b sp=%b we=%b a=%0d d=%h ir=%b",
                         i, accum, z_flag, c_flag, skip_pending, rf_we, rf_waddr, rf_wdata,
                         intr_return, m_accum, m_z, m_c, m_skip, m_rf_we, m_rf_waddr,
                         m_rf_wdata, m_intr);
            end
        end
        idle();
    endtask

    initial begin
        idle();
        test_reset();
        test_flags();
        test_rf_write();
        test_skip();
        test_interrupt();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
